// File: rtl/ram_bridge.sv
// Bridge from the picorv32 native memory bus to a single-port synchronous word RAM.
// Each request becomes exactly one RAM cycle, followed by optional wait states and a
// one-cycle mem_ready. Requests outside the RAM window never reach the RAM; they set a
// sticky error flag and complete normally.
module ram_bridge #(
    parameter logic [31:0] BASE   = 32'h0000_0000,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned WAIT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic              ram_ce,
    output logic [3:0]        ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_d,
    input  logic [31:0]       ram_q,
    output logic              err,
    output logic [31:0]       err_addr
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    // Counter load value so that WAIT cycles are spent in StWait.
    localparam logic [3:0] WaitLoad = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_read_q, is_read_d;
    logic        oor_q, oor_d;
    logic        err_q, err_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        in_range;

    // Byte-lane address bits carry no meaning for a word RAM.
    logic        unused_addr;
    assign unused_addr = ^mem_addr[1:0];

    assign in_range = (mem_addr[31:ADDR_W+2] == BASE[31:ADDR_W+2]);

    // Address, data and strobes go straight through; only ram_ce qualifies the access.
    assign ram_addr = mem_addr[ADDR_W+1:2];
    assign ram_d    = mem_wdata;
    assign ram_wr   = mem_wstrb;
    assign err      = err_q;
    assign err_addr = err_addr_q;

    // State and capture registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            is_read_q  <= 1'b0;
            oor_q      <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_read_q  <= is_read_d;
            oor_q      <= oor_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Next-state decode plus all bus-facing control outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_read_d  = is_read_q;
        oor_d      = oor_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        ram_ce     = 1'b0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'h0;

        unique case (state_q)
            StIdle: begin
                if (mem_valid) begin
                    ram_ce    = in_range;
                    is_read_d = (mem_wstrb == 4'h0);
                    oor_d     = !in_range;
                    if (!in_range) begin
                        err_d = 1'b1;
                        // Keep the first offending address only.
                        if (!err_q) begin
                            err_addr_d = mem_addr;
                        end
                    end
                    if (WAIT > 0) begin
                        cnt_d   = WaitLoad;
                        state_d = StWait;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                mem_ready = 1'b1;
                if (is_read_q) begin
                    mem_rdata = oor_q ? 32'hFFFF_FFFF : ram_q;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_ram_bridge.sv
// Bench for ram_bridge: one instance with WAIT=0 and one with WAIT=3, each with its
// own behavioural RAM. Expected read data goes into a scoreboard queue when a request
// is driven and is compared whenever a bridge raises mem_ready.
module tb_ram_bridge;

    localparam int unsigned AW = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [3:0]  mem_wstrb [2];
    logic        mem_ready [2];
    logic [31:0] mem_rdata [2];
    logic        ram_ce    [2];
    logic [3:0]  ram_wr    [2];
    logic [AW-1:0] ram_addr [2];
    logic [31:0] ram_d     [2];
    logic [31:0] ram_q     [2];
    logic        err       [2];
    logic [31:0] err_addr  [2];

    int checks = 0;
    int errors = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] mem [2**AW];

        ram_bridge #(
            .BASE   (32'h0000_0000),
            .ADDR_W (AW),
            .WAIT   ((g == 0) ? 0 : 3)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .mem_valid (mem_valid[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_wstrb (mem_wstrb[g]),
            .mem_ready (mem_ready[g]),
            .mem_rdata (mem_rdata[g]),
            .ram_ce    (ram_ce[g]),
            .ram_wr    (ram_wr[g]),
            .ram_addr  (ram_addr[g]),
            .ram_d     (ram_d[g]),
            .ram_q     (ram_q[g]),
            .err       (err[g]),
            .err_addr  (err_addr[g])
        );

        // Behavioural RAM: byte writes, registered read of the pre-write contents.
        always @(posedge clk) begin
            if (ram_ce[g]) begin
                ram_q[g] <= mem[ram_addr[g]];
                for (int b = 0; b < 4; b++) begin
                    if (ram_wr[g][b]) mem[ram_addr[g]][8*b +: 8] <= ram_d[g][8*b +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every completion must match the oldest expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_ready[d] === 1'b1) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    check("rdata", mem_rdata[d], sb.pop_front());
                end
            end
        end
    end

    // One request on instance d, driven at a falling edge; checks latency (in falling
    // edges from the drive point), RAM cycle count and RAM word address.
    task automatic txn(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] exp_rdata,
                       input int exp_lat, input int exp_ce, input bit keep);
        int lat = 0;
        int ces = 0;
        bit seen = 1'b0;
        sb.push_back(exp_rdata);
        mem_addr[d]  = addr;
        mem_wdata[d] = wdata;
        mem_wstrb[d] = wstrb;
        mem_valid[d] = 1'b1;
        #1;
        while (!seen && lat < 40) begin
            if (ram_ce[d]) begin
                ces++;
                check("ram_addr", 32'(ram_addr[d]), 32'(addr[AW+1:2]));
            end
            @(negedge clk);
            lat++;
            if (mem_ready[d] === 1'b1) seen = 1'b1;
        end
        check("latency", lat, exp_lat);
        check("ce_count", ces, exp_ce);
        if (!keep) begin
            mem_valid[d] = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            mem_valid[d] = 1'b0;
            mem_addr[d]  = 32'h0;
            mem_wdata[d] = 32'h0;
            mem_wstrb[d] = 4'h0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(mem_ready[d]), 32'd0);
            check("rst_rdata", mem_rdata[d], 32'h0);
            check("rst_ce", 32'(ram_ce[d]), 32'd0);
            check("rst_err", 32'(err[d]), 32'd0);
            check("rst_err_addr", err_addr[d], 32'h0);
        end

        // Basic write/read, no wait states.
        txn(0, 32'h100, 32'h1234_5678, 4'hF, 32'h0, 1, 1, 1'b0);
        txn(0, 32'h100, 32'h0, 4'h0, 32'h1234_5678, 1, 1, 1'b0);

        // Byte strobes.
        txn(0, 32'h8, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, 1, 1'b0);
        txn(0, 32'h8, 32'h0000_AB00, 4'b0010, 32'h0, 1, 1, 1'b0);
        txn(0, 32'h8, 32'h0, 4'h0, 32'hFFFF_ABFF, 1, 1, 1'b0);

        // Out of range: no RAM cycle, sticky error, first address kept.
        txn(0, 32'h0004_0000, 32'h0, 4'h0, 32'hFFFF_FFFF, 1, 0, 1'b0);
        check("err_set", 32'(err[0]), 32'd1);
        check("err_addr_first", err_addr[0], 32'h0004_0000);
        txn(0, 32'h0005_0000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1, 0, 1'b0);
        check("err_sticky", 32'(err[0]), 32'd1);
        check("err_addr_kept", err_addr[0], 32'h0004_0000);

        // Back-to-back reads with mem_valid held throughout.
        txn(0, 32'h10, 32'hA0A0_0001, 4'hF, 32'h0, 1, 1, 1'b0);
        txn(0, 32'h14, 32'hB0B0_0002, 4'hF, 32'h0, 1, 1, 1'b0);
        txn(0, 32'h18, 32'hC0C0_0003, 4'hF, 32'h0, 1, 1, 1'b0);
        txn(0, 32'h10, 32'h0, 4'h0, 32'hA0A0_0001, 1, 1, 1'b1);
        txn(0, 32'h14, 32'h0, 4'h0, 32'hB0B0_0002, 2, 1, 1'b1);
        txn(0, 32'h18, 32'h0, 4'h0, 32'hC0C0_0003, 2, 1, 1'b0);

        // Wait states: ready at 1+WAIT, single-cycle pulse.
        txn(1, 32'h200, 32'h5A5A_1234, 4'hF, 32'h0, 4, 1, 1'b0);
        txn(1, 32'h200, 32'h0, 4'h0, 32'h5A5A_1234, 4, 1, 1'b1);
        mem_valid[1] = 1'b0;
        @(negedge clk);
        check("ready_pulse", 32'(mem_ready[1]), 32'd0);

        // Reset while waiting: the read is dropped, error flags cleared.
        mem_addr[1]  = 32'h200;
        mem_wstrb[1] = 4'h0;
        mem_valid[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mem_valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rst_wait_noready", 32'(mem_ready[1]), 32'd0);
            @(negedge clk);
        end
        check("rst_err_cleared", 32'(err[0]), 32'd0);
        check("rst_err_addr_cleared", err_addr[0], 32'h0);
        txn(1, 32'h200, 32'h0, 4'h0, 32'h5A5A_1234, 4, 1, 1'b0);

        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
